// File: rtl/booth_pkg.sv
// Shared widths, accumulator FSM states and clamp limits for the Booth product accumulator.
package booth_pkg;

  localparam int unsigned PROD_W_DEF = 32;
  localparam int unsigned ACC_W_DEF  = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FULL = 2'd2
  } acc_state_e;

  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed accumulate: acc + sign-extended product, with overflow flag and optional clamp.
module booth_sat_add #(
  parameter int unsigned PROD_W   = 32,
  parameter int unsigned ACC_W    = 40,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum_c,
  output logic              o_ovf_c
);

  localparam logic [ACC_W-1:0] W_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] W_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_prod_ext;
  logic [ACC_W:0] w_sum;

  // One guard bit above ACC_W exposes signed overflow as a sign disagreement.
  assign w_prod_ext = {{(ACC_W+1-PROD_W){i_prod[PROD_W-1]}}, i_prod};
  assign w_sum      = {i_acc[ACC_W-1], i_acc} + w_prod_ext;
  assign o_ovf_c    = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    o_sum_c = w_sum[ACC_W-1:0];
    if (SATURATE && o_ovf_c) begin
      o_sum_c = w_sum[ACC_W] ? W_MIN : W_MAX;
    end
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Groups the signed product stream into dot-product sums and hands one result per group downstream.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned PROD_W   = PROD_W_DEF,
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic [15:0]       out_count
);

  acc_state_e       r_state,     w_state;
  logic [ACC_W-1:0] r_acc,       w_acc;
  logic [15:0]      r_cnt,       w_cnt;
  logic             r_ovf,       w_ovf_acc;
  logic [ACC_W-1:0] r_out_data,  w_out_data;
  logic             r_out_ovf,   w_out_ovf;
  logic [15:0]      r_out_count, w_out_count;

  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;
  logic             w_accept;
  logic [15:0]      w_cnt_inc;

  booth_sat_add #(
    .PROD_W   (PROD_W),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .i_acc   (r_acc),
    .i_prod  (in_prod),
    .o_sum_c (w_sum),
    .o_ovf_c (w_ovf)
  );

  assign out_valid = (r_state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_count = r_out_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_count <= '0;
    end else begin
      r_state     <= w_state;
      r_acc       <= w_acc;
      r_cnt       <= w_cnt;
      r_ovf       <= w_ovf_acc;
      r_out_data  <= w_out_data;
      r_out_ovf   <= w_out_ovf;
      r_out_count <= w_out_count;
    end
  end

  // Accumulator datapath and next state; a last beat always loads the result register.
  always_comb begin
    w_state     = r_state;
    w_acc       = r_acc;
    w_cnt       = r_cnt;
    w_ovf_acc   = r_ovf;
    w_out_data  = r_out_data;
    w_out_ovf   = r_out_ovf;
    w_out_count = r_out_count;

    if (w_accept && in_last) begin
      w_out_data  = w_sum;
      w_out_ovf   = r_ovf | w_ovf;
      w_out_count = w_cnt_inc;
      w_acc       = '0;
      w_cnt       = '0;
      w_ovf_acc   = 1'b0;
      w_state     = FULL;
    end else begin
      if (w_accept) begin
        w_acc     = w_sum;
        w_cnt     = w_cnt_inc;
        w_ovf_acc = r_ovf | w_ovf;
      end
      case (r_state)
        IDLE:    if (w_accept) w_state = ACC;
        ACC:     w_state = ACC;
        FULL:    if (out_ready) w_state = (w_cnt != 16'd0) ? ACC : IDLE;
        default: w_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Randomized bench: three accumulator flavours share one stimulus stream and are checked against an integer model.
module tb_booth_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [31:0] in_prod;

  logic        rdy_a, rdy_b, rdy_c;
  logic        val_a, val_b, val_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [39:0] dat_a;
  logic [32:0] dat_b, dat_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  always #5 clk = ~clk;

  booth_product_accumulator #(.PROD_W(32), .ACC_W(40), .SATURATE(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_prod(in_prod),
    .in_last(in_last), .out_valid(val_a), .out_ready(out_ready), .out_data(dat_a),
    .out_ovf(ovf_a), .out_count(cnt_a));

  booth_product_accumulator #(.PROD_W(32), .ACC_W(33), .SATURATE(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_prod(in_prod),
    .in_last(in_last), .out_valid(val_b), .out_ready(out_ready), .out_data(dat_b),
    .out_ovf(ovf_b), .out_count(cnt_b));

  booth_product_accumulator #(.PROD_W(32), .ACC_W(33), .SATURATE(1'b0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .in_prod(in_prod),
    .in_last(in_last), .out_valid(val_c), .out_ready(out_ready), .out_data(dat_c),
    .out_ovf(ovf_c), .out_count(cnt_c));

  int n_tests = 0;
  int n_fail  = 0;

  longint m_acc  [3];
  longint m_data [3];
  int     m_cnt  [3];
  int     m_count[3];
  bit     m_ovfacc[3];
  bit     m_ovf  [3];
  bit     m_valid;
  bit     dummy;

  function automatic int wid(input int k);
    return (k == 0) ? 40 : 33;
  endfunction

  function automatic bit sat(input int k);
    return (k != 2);
  endfunction

  // Mathematical sum, then clamp or wrap into the W-bit signed range.
  function automatic longint add_model(input int k, input longint a, input longint p, output bit o);
    longint mx, mn, span, s;
    span = 64'sd1 <<< wid(k);
    mx   = (64'sd1 <<< (wid(k) - 1)) - 64'sd1;
    mn   = -(64'sd1 <<< (wid(k) - 1));
    s    = a + p;
    o    = (s > mx) || (s < mn);
    if (o) begin
      if (sat(k)) s = (s > mx) ? mx : mn;
      else        s = (s > mx) ? s - span : s + span;
    end
    return s;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0; m_data[k] = 0; m_cnt[k] = 0; m_count[k] = 0;
      m_ovfacc[k] = 1'b0; m_ovf[k] = 1'b0;
    end
    m_valid = 1'b0;
  endtask

  task automatic model_step(input bit acc, input logic [31:0] p, input bit l, input bit r);
    longint s;
    bit     o;
    for (int k = 0; k < 3; k++) begin
      if (acc) begin
        s = add_model(k, m_acc[k], 64'($signed(p)), o);
        if (l) begin
          m_data[k]   = s;
          m_ovf[k]    = m_ovfacc[k] | o;
          m_count[k]  = (m_cnt[k] == 65535) ? 65535 : m_cnt[k] + 1;
          m_acc[k]    = 0;
          m_cnt[k]    = 0;
          m_ovfacc[k] = 1'b0;
        end else begin
          m_acc[k]    = s;
          m_cnt[k]    = (m_cnt[k] == 65535) ? 65535 : m_cnt[k] + 1;
          m_ovfacc[k] = m_ovfacc[k] | o;
        end
      end
    end
    if (acc && l)    m_valid = 1'b1;
    else if (r)      m_valid = 1'b0;
  endtask

  task automatic compare_outputs();
    check("valid_a", 64'(val_a), 64'(m_valid));
    check("valid_b", 64'(val_b), 64'(m_valid));
    check("valid_c", 64'(val_c), 64'(m_valid));
    check("data_a",  64'($signed(dat_a)), m_data[0]);
    check("data_b",  64'($signed(dat_b)), m_data[1]);
    check("data_c",  64'($signed(dat_c)), m_data[2]);
    check("ovf_a",   64'(ovf_a), 64'(m_ovf[0]));
    check("ovf_b",   64'(ovf_b), 64'(m_ovf[1]));
    check("ovf_c",   64'(ovf_c), 64'(m_ovf[2]));
    check("count_a", 64'(cnt_a), 64'(m_count[0]));
    check("count_b", 64'(cnt_b), 64'(m_count[1]));
    check("count_c", 64'(cnt_c), 64'(m_count[2]));
  endtask

  // Drive one cycle from just after a falling edge; returns whether the beat was taken.
  task automatic cycle(input bit v, input logic [31:0] p, input bit l, input bit r, output bit acc);
    bit exp_rdy;
    in_valid  = v;
    in_prod   = v ? p : 32'hxxxx_xxxx;
    in_last   = v & l;
    out_ready = r;
    #1;
    exp_rdy = !m_valid || r;
    check("in_ready_a", 64'(rdy_a), 64'(exp_rdy));
    check("in_ready_b", 64'(rdy_b), 64'(exp_rdy));
    check("in_ready_c", 64'(rdy_c), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    model_step(acc, p, l, r);
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pp;
    bit          have, lv, rr, took;

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b1;
    model_reset();
    #3;
    check("rst_in_ready", 64'(rdy_a), 64'd1);
    check("rst_valid",    64'(val_a), 64'd0);
    check("rst_data",     64'(dat_a), 64'd0);
    check("rst_ovf",      64'(ovf_b), 64'd0);
    check("rst_count",    64'(cnt_c), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-term group: 7FFF*7FFF plus -1.
    cycle(1'b1, 32'h3FFF_0001, 1'b0, 1'b1, dummy);
    check("t1_no_early_valid", 64'(val_a), 64'd0);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, dummy);
    check("t1_valid", 64'(val_a), 64'd1);
    check("t1_data",  64'(dat_a), 64'h0000_003F_FF00_00);
    check("t1_count", 64'(cnt_a), 64'd2);
    check("t1_ovf",   64'(ovf_a), 64'd0);

    // Single-beat group of the most negative product.
    cycle(1'b1, 32'h8000_0000, 1'b1, 1'b1, dummy);
    check("t2_data",  64'(dat_a), 64'h0000_00FF_8000_0000);
    check("t2_count", 64'(cnt_a), 64'd1);

    // Overflow in a 33-bit accumulator: clamp versus wrap.
    cycle(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, dummy);
    cycle(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, dummy);
    cycle(1'b1, 32'h0000_0002, 1'b1, 1'b1, dummy);
    check("t3_sat_data",  64'(dat_b), 64'h0_FFFF_FFFF);
    check("t3_sat_ovf",   64'(ovf_b), 64'd1);
    check("t3_wrap_data", 64'(dat_c), 64'h1_0000_0000);
    check("t3_wrap_ovf",  64'(ovf_c), 64'd1);
    check("t3_wide_data", 64'(dat_a), 64'h1_0000_0000);
    check("t3_wide_ovf",  64'(ovf_a), 64'd0);
    check("t3_count",     64'(cnt_a), 64'd3);

    // Back-pressure: result held, beats refused.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'd99, 1'b0, 1'b0, took);
      check("t4_refused", 64'(took), 64'd0);
    end
    check("t4_hold_ready", 64'(rdy_a), 64'd0);
    check("t4_hold_data",  64'(dat_a), 64'h1_0000_0000);
    cycle(1'b1, 32'd5, 1'b1, 1'b1, dummy);
    check("t4_new_valid", 64'(val_a), 64'd1);
    check("t4_new_data",  64'(dat_a), 64'd5);
    check("t4_new_count", 64'(cnt_a), 64'd1);

    // Asynchronous reset in the middle of a group while clk is low.
    cycle(1'b1, 32'd10, 1'b1, 1'b1, dummy);
    cycle(1'b1, 32'd1,  1'b0, 1'b1, dummy);
    cycle(1'b1, 32'd2,  1'b0, 1'b1, dummy);
    cycle(1'b1, 32'd3,  1'b0, 1'b0, dummy);
    check("t5_pre_data", 64'(dat_a), 64'd10);
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t5_rst_data",  64'(dat_a), 64'd0);
    check("t5_rst_count", 64'(cnt_a), 64'd0);
    check("t5_rst_valid", 64'(val_a), 64'd0);
    check("t5_rst_ready", 64'(rdy_a), 64'd1);
    compare_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'd7, 1'b1, 1'b1, dummy);
    check("t5_after_data",  64'(dat_a), 64'd7);
    check("t5_after_count", 64'(cnt_a), 64'd1);

    // Random stream with random back-pressure; a refused beat is held until taken.
    have = 1'b0; pp = '0; lv = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!have) begin
        have = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 3))
          0:       pp = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
          1:       pp = 32'($urandom_range(0, 2000)) - 32'd1000;
          default: pp = $urandom;
        endcase
        lv = ($urandom_range(0, 3) == 0);
      end
      rr = ($urandom_range(0, 9) < 6);
      cycle(have, pp, lv, rr, took);
      if (took) have = 1'b0;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1, dummy);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
